// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg: shared ASCII constants, checker verdict encodings and capture states
package cpu_trace_pkg;
    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_LT     = 8'h3C;
    localparam logic [7:0] CH_EQ     = 8'h3D;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    localparam logic [1:0] FMT_NONE = 2'b00;
    localparam logic [1:0] FMT_GRF  = 2'b01;
    localparam logic [1:0] FMT_MEM  = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_TIME, S_PC, S_SEP, S_REG, S_ADDR, S_PRE_EQ, S_EQ_WS, S_DATA
    } cap_state_e;
endpackage

// File: rtl/hex_char_decode.sv
// hex_char_decode: classifies an ASCII character as decimal/lowercase-hex digit and yields its nibble
module hex_char_decode (
    input  logic [7:0] char,
    output logic [3:0] nib,
    output logic       is_hex,
    output logic       is_dec
);
    logic is_alpha;

    assign is_dec   = (char >= 8'h30) && (char <= 8'h39);
    assign is_alpha = (char >= 8'h61) && (char <= 8'h66);
    assign is_hex   = is_dec || is_alpha;
    assign nib      = is_dec ? char[3:0] : char[3:0] + 4'd9;
endmodule

// File: rtl/cpu_record_extractor.sv
// cpu_record_extractor: captures numeric fields of trace records and emits them when the checker accepts one
module cpu_record_extractor
    import cpu_trace_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  char,
    input  logic [1:0]  format_type,
    output logic        rec_valid,
    output logic [1:0]  rec_type,
    output logic [15:0] rec_time,
    output logic [31:0] rec_pc,
    output logic [31:0] rec_dst,
    output logic [31:0] rec_data,
    output logic [15:0] grf_count,
    output logic [15:0] mem_count
);
    cap_state_e  state_q, state_d;
    logic [15:0] time_q, time_d;
    logic [31:0] pc_q, pc_d, dst_q, dst_d, data_q, data_d;
    logic [3:0]  nib;
    logic        is_hex, is_dec, emit;

    hex_char_decode u_dec (.char(char), .nib(nib), .is_hex(is_hex), .is_dec(is_dec));

    assign emit = (format_type == FMT_GRF) || (format_type == FMT_MEM);

    always_comb begin
        state_d = S_IDLE;
        time_d  = time_q;
        pc_d    = pc_q;
        dst_d   = dst_q;
        data_d  = data_q;
        if (char == CH_CARET) begin
            state_d = S_TIME;
            time_d  = '0;
            pc_d    = '0;
            dst_d   = '0;
            data_d  = '0;
        end else begin
            case (state_q)
                S_TIME: begin
                    if (is_dec) begin
                        state_d = S_TIME;
                        time_d  = time_q * 16'd10 + {12'd0, nib};
                    end else if (char == CH_AT) state_d = S_PC;
                end
                S_PC: begin
                    if (is_hex) begin
                        state_d = S_PC;
                        pc_d    = {pc_q[27:0], nib};
                    end else if (char == CH_COLON) state_d = S_SEP;
                end
                S_SEP: begin
                    if (char == CH_SPACE) state_d = S_SEP;
                    else if (char == CH_DOLLAR) state_d = S_REG;
                    else if (char == CH_STAR) state_d = S_ADDR;
                end
                S_REG, S_ADDR: begin
                    if (state_q == S_REG && is_dec) begin
                        state_d = S_REG;
                        dst_d   = dst_q * 32'd10 + {28'd0, nib};
                    end else if (state_q == S_ADDR && is_hex) begin
                        state_d = S_ADDR;
                        dst_d   = {dst_q[27:0], nib};
                    end else if (char == CH_SPACE) begin
                        // blanks before the first digit ("$ 2") keep us in the field
                        state_d = (dst_q == '0) ? state_q : S_PRE_EQ;
                    end else if (char == CH_LT) state_d = S_EQ_WS;
                end
                S_PRE_EQ: begin
                    if (char == CH_SPACE) state_d = S_PRE_EQ;
                    else if (char == CH_LT) state_d = S_EQ_WS;
                end
                S_EQ_WS, S_DATA: begin
                    if (is_hex) begin
                        state_d = S_DATA;
                        data_d  = {data_q[27:0], nib};
                    end else if (state_q == S_EQ_WS && (char == CH_EQ || char == CH_SPACE)) begin
                        state_d = S_EQ_WS;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            time_q    <= '0;
            pc_q      <= '0;
            dst_q     <= '0;
            data_q    <= '0;
            rec_valid <= 1'b0;
            rec_type  <= '0;
            rec_time  <= '0;
            rec_pc    <= '0;
            rec_dst   <= '0;
            rec_data  <= '0;
            grf_count <= '0;
            mem_count <= '0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            pc_q      <= pc_d;
            dst_q     <= dst_d;
            data_q    <= data_d;
            rec_valid <= emit;
            if (emit) begin
                rec_type <= format_type;
                rec_time <= time_q;
                rec_pc   <= pc_q;
                rec_dst  <= dst_q;
                rec_data <= data_q;
            end
            if (format_type == FMT_GRF && grf_count != 16'hFFFF) grf_count <= grf_count + 16'd1;
            if (format_type == FMT_MEM && mem_count != 16'hFFFF) mem_count <= mem_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_cpu_record_extractor.sv
// tb_cpu_record_extractor: directed record strings with a bench-side checker model driving format_type
module tb_cpu_record_extractor;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  char;
    logic [1:0]  format_type;
    logic        rec_valid;
    logic [1:0]  rec_type;
    logic [15:0] rec_time;
    logic [31:0] rec_pc, rec_dst, rec_data;
    logic [15:0] grf_count, mem_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int npulse = 0;
    int p_cyc [4];
    logic [31:0] p_dst [4];
    string s1, s2;

    cpu_record_extractor dut (
        .clk(clk), .reset(reset), .char(char), .format_type(format_type),
        .rec_valid(rec_valid), .rec_type(rec_type), .rec_time(rec_time),
        .rec_pc(rec_pc), .rec_dst(rec_dst), .rec_data(rec_data),
        .grf_count(grf_count), .mem_count(mem_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [7:0] c, input logic [1:0] f);
        char = c;
        format_type = f;
        @(posedge clk);
        #1;
        cyc++;
        if (rec_valid) begin
            if (npulse < 4) begin
                p_cyc[npulse] = cyc;
                p_dst[npulse] = rec_dst;
            end
            npulse++;
        end
    endtask

    // the checker model flags the cycle right after each '#' with the given verdict
    task automatic send(input string s, input logic [1:0] fmt);
        logic [1:0] p;
        p = 2'b00;
        for (int i = 0; i < s.len(); i++) begin
            step(s[i], p);
            p = (s[i] == "#") ? fmt : 2'b00;
        end
        step(8'h00, p);
        step(8'h00, 2'b00);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(8'h00, 2'b00);
        step(8'h00, 2'b00);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        char = 8'h00;
        format_type = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, rec_valid}, 0);
        chk("rst_time", {16'd0, rec_time}, 0);
        chk("rst_pc", rec_pc, 0);
        chk("rst_grf", {16'd0, grf_count}, 0);
        chk("rst_mem", {16'd0, mem_count}, 0);
        reset = 1'b0;

        npulse = 0;
        send("^10@00003000: $ 2 <= 0000abcd#", 2'b01);
        chk("grf_pulses", npulse, 1);
        chk("grf_type", {30'd0, rec_type}, 1);
        chk("grf_time", {16'd0, rec_time}, 10);
        chk("grf_pc", rec_pc, 32'h3000);
        chk("grf_dst", rec_dst, 2);
        chk("grf_data", rec_data, 32'habcd);
        chk("grf_cnt", {16'd0, grf_count}, 1);
        chk("grf_mem_cnt", {16'd0, mem_count}, 0);
        chk("grf_pulse_end", {31'd0, rec_valid}, 0);

        npulse = 0;
        send("^5@0000300c: *00001004 <= 12345678#", 2'b10);
        chk("mem_pulses", npulse, 1);
        chk("mem_type", {30'd0, rec_type}, 2);
        chk("mem_time", {16'd0, rec_time}, 5);
        chk("mem_pc", rec_pc, 32'h300c);
        chk("mem_dst", rec_dst, 32'h1004);
        chk("mem_data", rec_data, 32'h12345678);
        chk("mem_cnt", {16'd0, mem_count}, 1);
        chk("mem_grf_cnt", {16'd0, grf_count}, 1);

        npulse = 0;
        s1 = "^1@00000010: $3 <= 00000011#";
        s2 = "^2@00000020: $7 <= 00000022#";
        send({s1, s2}, 2'b01);
        chk("b2b_pulses", npulse, 2);
        chk("b2b_spacing", p_cyc[1] - p_cyc[0], s2.len());
        chk("b2b_dst0", p_dst[0], 3);
        chk("b2b_time", {16'd0, rec_time}, 2);
        chk("b2b_pc", rec_pc, 32'h20);
        chk("b2b_dst", rec_dst, 7);
        chk("b2b_data", rec_data, 32'h22);
        chk("b2b_grf_cnt", {16'd0, grf_count}, 3);

        npulse = 0;
        send("^10@3000: $2 <= 0000abcd#", 2'b00);
        chk("bad_pulses", npulse, 0);
        chk("bad_grf_cnt", {16'd0, grf_count}, 3);
        chk("bad_mem_cnt", {16'd0, mem_count}, 1);

        npulse = 0;
        send("^7@00000004: $1 <= 0000", 2'b00);
        do_reset();
        chk("abort_grf_cnt", {16'd0, grf_count}, 0);
        chk("abort_data", rec_data, 0);
        send("ff#", 2'b00);
        send("^9@00000008: $4 <= 0000beef#", 2'b01);
        chk("abort_pulses", npulse, 1);
        chk("abort_time", {16'd0, rec_time}, 9);
        chk("abort_pc", rec_pc, 32'h8);
        chk("abort_dst", rec_dst, 4);
        chk("abort_data2", rec_data, 32'hbeef);
        chk("abort_grf_cnt2", {16'd0, grf_count}, 1);

        do_reset();
        for (int i = 0; i < 65534; i++) step(8'h00, 2'b01);
        step(8'h00, 2'b00);
        chk("sat_fffe", {16'd0, grf_count}, 32'hfffe);
        for (int i = 0; i < 3; i++) send("^10@00003000: $ 2 <= 0000abcd#", 2'b01);
        chk("sat_ffff", {16'd0, grf_count}, 32'hffff);
        chk("sat_mem", {16'd0, mem_count}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
